rtl_req_arbiter: RTL and testbench



---
 rtl/rtl_req_arbiter.sv | 108 ++++++++++
 tb/tb_rtl_req_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rtl_req_arbiter.sv
// rtl/rtl_req_arbiter.sv - three-way round-robin arbiter feeding a small output FIFO with source tags
module rtl_req_arbiter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             req_0_valid,
    input  logic             req_1_valid,
    input  logic             req_2_valid,
    output logic             req_0_ready,
    output logic             req_1_ready,
    output logic             req_2_ready,
    input  logic [WIDTH-1:0] req_0_data,
    input  logic [WIDTH-1:0] req_1_data,
    input  logic [WIDTH-1:0] req_2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic [7:0]       stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]       ptr;
    logic [CW-1:0]    count;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [WIDTH+1:0] mem [DEPTH];

    logic [2:0]       valids;
    logic [2:0]       idx;
    logic             win_found;
    logic [1:0]       winner;
    logic [WIDTH-1:0] win_data;
    logic             not_full;
    logic             push;
    logic             pop;

    assign valids = {req_2_valid, req_1_valid, req_0_valid};

    // Search starts at ptr and wraps 2 -> 0; first valid index wins.
    always_comb begin
        win_found = 1'b0;
        winner    = 2'd0;
        idx       = 3'd0;
        for (int i = 0; i < 3; i++) begin
            idx = {1'b0, ptr} + 3'(i);
            if (idx >= 3'd3) idx = idx - 3'd3;
            if (!win_found && valids[idx]) begin
                win_found = 1'b1;
                winner    = idx[1:0];
            end
        end
    end

    always_comb begin
        win_data = req_0_data;
        case (winner)
            2'd1:    win_data = req_1_data;
            2'd2:    win_data = req_2_data;
            default: win_data = req_0_data;
        endcase
    end

    // A full FIFO blocks pushes even when a pop lands in the same cycle, so
    // requester ready never depends on out_ready.
    assign not_full    = (count < CW'(DEPTH));
    assign push        = ASYNCRESETN && not_full && win_found;
    assign req_0_ready = push && (winner == 2'd0);
    assign req_1_ready = push && (winner == 2'd1);
    assign req_2_ready = push && (winner == 2'd2);

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
    assign out_src   = out_valid ? mem[rd_ptr][WIDTH+1:WIDTH] : 2'd0;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {winner, win_data};
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            ptr       <= 2'd0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            stall_cnt <= 8'd0;
        end else begin
            if (push) begin
                ptr    <= (winner == 2'd2) ? 2'd0 : winner + 2'd1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (out_valid && !out_ready && stall_cnt != 8'hFF)
                stall_cnt <= stall_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rtl_req_arbiter.sv
// tb/tb_rtl_req_arbiter.sv - scoreboard bench for rtl_req_arbiter
module tb_rtl_req_arbiter;

    logic       CLK;
    logic       ASYNCRESETN;
    logic       req_0_valid, req_1_valid, req_2_valid;
    logic       req_0_ready, req_1_ready, req_2_ready;
    logic [3:0] req_0_data, req_1_data, req_2_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic [7:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q [$];

    rtl_req_arbiter #(.WIDTH(4), .DEPTH(2)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .req_0_valid(req_0_valid), .req_1_valid(req_1_valid), .req_2_valid(req_2_valid),
        .req_0_ready(req_0_ready), .req_1_ready(req_1_ready), .req_2_ready(req_2_ready),
        .req_0_data(req_0_data), .req_1_data(req_1_data), .req_2_data(req_2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .stall_cnt(stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_rdy(input string name, input logic [2:0] req);
        chk(name, int'({req_2_ready, req_1_ready, req_0_ready}), int'(req));
    endtask

    task automatic expect_beat(input int src, input int data);
        exp_q.push_back({2'(src), 4'(data)});
    endtask

    task automatic set_valids(input logic [2:0] v);
        {req_2_valid, req_1_valid, req_0_valid} = v;
    endtask

    task automatic idle(input int n);
        set_valids(3'b000);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: sample just before each rising edge and check every accepted beat.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge CLK);
            #4;
            if (ASYNCRESETN && out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat actual=%0h/%0h required=none", out_src, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_src, out_data} !== e) begin
                        bad++;
                        $display("FAIL beat actual=%0h/%0h required=%0h/%0h",
                                 out_src, out_data, e[5:4], e[3:0]);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] rr_grant [7];
        rr_grant = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

        // Reset: readies stay low even with a valid requester.
        ASYNCRESETN = 1'b0;
        out_ready   = 1'b0;
        req_0_data  = 4'h0; req_1_data = 4'h0; req_2_data = 4'h0;
        set_valids(3'b001);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_src", int'(out_src), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        chk_rdy("rst_ready", 3'b000);
        set_valids(3'b000);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;

        // Single beat from requester 1.
        @(negedge CLK);
        req_1_valid = 1'b1; req_1_data = 4'hA; out_ready = 1'b1;
        #1 chk_rdy("single_ready", 3'b010);
        expect_beat(1, 4'hA);
        @(negedge CLK);
        set_valids(3'b111);
        req_0_data = 4'h1; req_1_data = 4'h2; req_2_data = 4'h3;
        #1;
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_data", int'(out_data), 4'hA);
        chk("lat_src", int'(out_src), 1);

        // Round robin: ptr is 2 after the requester-1 push.
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                @(negedge CLK);
                #1;
            end
            chk_rdy($sformatf("rr_grant%0d", i), 3'(1 << rr_grant[i]));
            expect_beat(int'(rr_grant[i]), int'(rr_grant[i]) + 1);
        end
        @(negedge CLK);
        idle(3);

        // Full backpressure on requester 0.
        out_ready = 1'b0;
        req_0_valid = 1'b1; req_0_data = 4'h5;
        #1 chk_rdy("bp_push5", 3'b001);
        expect_beat(0, 4'h5);
        @(negedge CLK);
        req_0_data = 4'h6;
        #1 chk_rdy("bp_push6", 3'b001);
        expect_beat(0, 4'h6);
        @(negedge CLK);
        req_0_data = 4'h7;
        #1 chk_rdy("bp_full", 3'b000);
        chk("bp_stall1", int'(stall_cnt), 1);
        repeat (3) begin
            @(negedge CLK);
            #1 chk_rdy("bp_hold", 3'b000);
        end
        chk("bp_stall4", int'(stall_cnt), 4);
        out_ready = 1'b1;
        #1 chk_rdy("bp_release_full", 3'b000);
        @(negedge CLK);
        #1 chk_rdy("bp_push7", 3'b001);
        expect_beat(0, 4'h7);
        @(negedge CLK);
        idle(3);
        chk("bp_stall_after", int'(stall_cnt), 4);

        // Full with a pop in the same cycle; ptr is 1 here.
        out_ready = 1'b0;
        req_2_valid = 1'b1; req_2_data = 4'h9;
        #1 chk_rdy("fp_push9", 3'b100);
        expect_beat(2, 4'h9);
        @(negedge CLK);
        req_2_data = 4'hB;
        #1 chk_rdy("fp_pushB", 3'b100);
        expect_beat(2, 4'hB);
        @(negedge CLK);
        out_ready = 1'b1; req_2_data = 4'hC;
        #1 chk_rdy("fp_full_pop", 3'b000);
        @(negedge CLK);
        #1 chk_rdy("fp_pushC", 3'b100);
        expect_beat(2, 4'hC);
        @(negedge CLK);
        idle(3);
        chk("fp_stall", int'(stall_cnt), 5);

        // Sparse requesters with ptr wrapped to 2.
        req_1_valid = 1'b1; req_1_data = 4'h4;
        #1 chk_rdy("sp_setup", 3'b010);
        expect_beat(1, 4'h4);
        @(negedge CLK);
        req_0_valid = 1'b1; req_0_data = 4'hD; req_1_data = 4'hE;
        #1 chk_rdy("sp_win0", 3'b001);
        expect_beat(0, 4'hD);
        @(negedge CLK);
        #1 chk_rdy("sp_win1", 3'b010);
        expect_beat(1, 4'hE);
        @(negedge CLK);
        #1 chk_rdy("sp_win0b", 3'b001);
        expect_beat(0, 4'hD);
        @(negedge CLK);
        idle(3);

        // Stall saturation, then an asynchronous reset pulse between edges.
        out_ready = 1'b0;
        req_0_valid = 1'b1; req_0_data = 4'h3;
        @(negedge CLK);
        set_valids(3'b000);
        repeat (300) @(negedge CLK);
        #1 chk("sat_stall", int'(stall_cnt), 255);
        chk("sat_valid", int'(out_valid), 1);
        ASYNCRESETN = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_stall", int'(stall_cnt), 0);
        chk("arst_data", int'(out_data), 0);
        #1 ASYNCRESETN = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge CLK);
        #1 chk("post_rst_valid", int'(out_valid), 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
